// File: rtl/overlay_scheduler.sv
// Frame-rate sequencer for the VGA text overlay: rotates the displayed texts,
// animates the shadow offset in the ALL slot and gates blinking near slot end.
module overlay_scheduler #(
  parameter int HOLD_FRAMES  = 120,
  parameter int SHADOW_MAX   = 4,
  parameter int BLINK_WINDOW = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       skip,
  output logic [2:0] text_en,
  output logic [2:0] shadow_off,
  output logic       blink_on,
  output logic [1:0] slot
);

  generate
    if (HOLD_FRAMES < 2 || HOLD_FRAMES > 1023) begin : g_bad_hold
      $error("overlay_scheduler: HOLD_FRAMES must be in 2..1023");
    end
    if (SHADOW_MAX < 1 || SHADOW_MAX > 7) begin : g_bad_shadow
      $error("overlay_scheduler: SHADOW_MAX must be in 1..7");
    end
    if (BLINK_WINDOW < 0 || (BLINK_WINDOW % 8) != 0 || BLINK_WINDOW >= HOLD_FRAMES) begin : g_bad_blink
      $error("overlay_scheduler: BLINK_WINDOW must be a multiple of 8 below HOLD_FRAMES");
    end
  endgenerate

  localparam logic [9:0] HOLD_LAST   = 10'(HOLD_FRAMES - 1);
  localparam logic [9:0] BLINK_START = 10'(HOLD_FRAMES - BLINK_WINDOW);
  localparam logic [2:0] SHADOW_REST = 3'(SHADOW_MAX);

  typedef enum logic [1:0] {
    S_DEMO = 2'd0,
    S_TT08 = 2'd1,
    S_SDA  = 2'd2,
    S_ALL  = 2'd3
  } slot_t;

  slot_t      state;
  logic [9:0] frame_cnt;
  logic       skip_req;
  logic       shadow_up;

  logic       active_tick;
  logic       advance;
  logic [9:0] frame_cnt_inc;
  logic [3:0] shadow_nxt;

  function automatic slot_t next_slot(input slot_t s);
    case (s)
      S_DEMO:  return S_TT08;
      S_TT08:  return S_SDA;
      S_SDA:   return S_ALL;
      default: return S_DEMO;
    endcase
  endfunction

  function automatic logic [2:0] enables_of(input slot_t s);
    case (s)
      S_DEMO:  return 3'b001;
      S_TT08:  return 3'b010;
      S_SDA:   return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  // Text is hidden on every other group of 4 frames inside the closing window.
  function automatic logic blink_of(input logic [9:0] n);
    return !((n >= BLINK_START) && n[2]);
  endfunction

  // Returns {dir_up, offset}; bounces between 1 and SHADOW_MAX, never outside.
  function automatic logic [3:0] shadow_step(input logic [2:0] off, input logic up);
    if (SHADOW_MAX == 1)
      return {1'b0, off};
    if (up) begin
      if (off >= SHADOW_REST)
        return {1'b0, off - 3'd1};
      return {1'b1, off + 3'd1};
    end
    if (off <= 3'd1)
      return {1'b1, off + 3'd1};
    return {1'b0, off - 3'd1};
  endfunction

  assign active_tick   = frame_tick & enable;
  assign advance       = (frame_cnt == HOLD_LAST) | skip_req | skip;
  assign frame_cnt_inc = frame_cnt + 10'd1;
  assign shadow_nxt    = shadow_step(shadow_off, shadow_up);
  assign slot          = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_DEMO;
      text_en    <= 3'b001;
      shadow_off <= SHADOW_REST;
      shadow_up  <= 1'b0;
      blink_on   <= 1'b1;
      frame_cnt  <= 10'd0;
      skip_req   <= 1'b0;
    end else if (active_tick) begin
      // Any pending skip is consumed here: advance is forced whenever one exists.
      skip_req <= 1'b0;
      if (advance) begin
        state      <= next_slot(state);
        text_en    <= enables_of(next_slot(state));
        frame_cnt  <= 10'd0;
        shadow_off <= SHADOW_REST;
        shadow_up  <= 1'b0;
        blink_on   <= 1'b1;
      end else begin
        frame_cnt <= frame_cnt_inc;
        blink_on  <= blink_of(frame_cnt_inc);
        if (state == S_ALL) begin
          shadow_off <= shadow_nxt[2:0];
          shadow_up  <= shadow_nxt[3];
        end
      end
    end else if (skip) begin
      skip_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_overlay_scheduler.sv
// Directed bench for overlay_scheduler: three parameterisations share one
// stimulus stream; each scenario checks the instance it targets.
module tb_overlay_scheduler;

  logic clk;
  logic rst_n;
  logic frame_tick;
  logic enable;
  logic skip;

  logic [2:0] text_en_a, shadow_a, text_en_b, shadow_b, text_en_c, shadow_c;
  logic       blink_a, blink_b, blink_c;
  logic [1:0] slot_a, slot_b, slot_c;

  int n_cmp = 0;
  int n_bad = 0;

  overlay_scheduler #(.HOLD_FRAMES(4), .SHADOW_MAX(4), .BLINK_WINDOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable), .skip(skip),
    .text_en(text_en_a), .shadow_off(shadow_a), .blink_on(blink_a), .slot(slot_a)
  );

  overlay_scheduler #(.HOLD_FRAMES(20), .SHADOW_MAX(4), .BLINK_WINDOW(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable), .skip(skip),
    .text_en(text_en_b), .shadow_off(shadow_b), .blink_on(blink_b), .slot(slot_b)
  );

  overlay_scheduler #(.HOLD_FRAMES(32), .SHADOW_MAX(4), .BLINK_WINDOW(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable), .skip(skip),
    .text_en(text_en_c), .shadow_off(shadow_c), .blink_on(blink_c), .slot(slot_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_tick(input logic with_skip);
    @(negedge clk);
    frame_tick = 1'b1;
    skip       = with_skip;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    skip       = 1'b0;
  endtask

  logic [2:0]  en_tbl [4] = '{3'b001, 3'b010, 3'b100, 3'b111};
  logic [2:0]  sh_tbl [20] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1,
                               3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
  logic [31:0] blink_tbl;

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    enable     = 1'b1;
    skip       = 1'b0;

    // Reset values on every instance
    do_reset();
    chk("rst_en_a",    32'(text_en_a), 32'h1);
    chk("rst_slot_a",  32'(slot_a),    32'h0);
    chk("rst_sh_a",    32'(shadow_a),  32'h4);
    chk("rst_blink_a", 32'(blink_a),   32'h1);
    chk("rst_en_b",    32'(text_en_b), 32'h1);
    chk("rst_slot_b",  32'(slot_b),    32'h0);
    chk("rst_en_c",    32'(text_en_c), 32'h1);
    chk("rst_slot_c",  32'(slot_c),    32'h0);
    chk("rst_sh_c",    32'(shadow_c),  32'h4);

    // Slot rotation with HOLD_FRAMES=4; output changes one clock after the tick
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      chk("rot_pre", 32'(text_en_a), 32'(en_tbl[((k - 1) / 4) % 4]));
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      chk("rot_en",   32'(text_en_a), 32'(en_tbl[(k / 4) % 4]));
      chk("rot_slot", 32'(slot_a),    32'((k / 4) % 4));
    end

    // Reset mid-ALL with shadow at 2; skip and tick asserted during reset are ignored
    do_reset();
    for (int k = 0; k < 14; k++) do_tick(1'b0);
    chk("ra_slot_pre", 32'(slot_a),   32'h3);
    chk("ra_sh_pre",   32'(shadow_a), 32'h2);
    @(negedge clk);
    rst_n      = 1'b0;
    frame_tick = 1'b1;
    skip       = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    skip       = 1'b0;
    chk("ra_en",    32'(text_en_a), 32'h1);
    chk("ra_slot",  32'(slot_a),    32'h0);
    chk("ra_sh",    32'(shadow_a),  32'h4);
    chk("ra_blink", 32'(blink_a),   32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) do_tick(1'b0);
    chk("ra_hold", 32'(slot_a), 32'h0);
    do_tick(1'b0);
    chk("ra_adv", 32'(slot_a), 32'h1);

    // Shadow bounce in ALL for HOLD_FRAMES=20; blink window n=12..15
    do_reset();
    for (int k = 0; k < 3; k++) do_tick(1'b1);
    chk("sh_entry_slot", 32'(slot_b),   32'h3);
    chk("sh_entry",      32'(shadow_b), 32'h4);
    for (int j = 1; j < 20; j++) begin
      do_tick(1'b0);
      chk("sh_step",  32'(shadow_b), 32'(sh_tbl[j]));
      chk("sh_blink", 32'(blink_b),  (j >= 12 && j <= 15) ? 32'h0 : 32'h1);
    end
    do_tick(1'b0);
    chk("sh_exit_en", 32'(text_en_b), 32'h1);
    chk("sh_exit",    32'(shadow_b),  32'h4);

    // Mid-frame skip in TT08, then a skip coincident with a tick
    do_reset();
    for (int k = 0; k < 5; k++) do_tick(1'b0);
    chk("sk_tt08", 32'(slot_a), 32'h1);
    @(negedge clk);
    skip = 1'b1;
    @(negedge clk);
    skip = 1'b0;
    repeat (3) @(negedge clk);
    chk("sk_wait", 32'(slot_a), 32'h1);
    do_tick(1'b0);
    chk("sk_adv",   32'(slot_a),    32'h2);
    chk("sk_adv_en", 32'(text_en_a), 32'h4);
    do_tick(1'b0);
    chk("sk_cleared", 32'(slot_a), 32'h2);
    do_tick(1'b1);
    chk("sk_coinc", 32'(slot_a), 32'h3);
    do_tick(1'b0);
    chk("sk_coinc_clr", 32'(slot_a), 32'h3);

    // enable=0 freezes state while a skip is still latched
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_tick(1'b0);
      if (i == 4) begin
        @(negedge clk);
        skip = 1'b1;
        @(negedge clk);
        skip = 1'b0;
      end
      chk("frz_slot", 32'(slot_a), 32'h0);
    end
    chk("frz_en",    32'(text_en_a), 32'h1);
    chk("frz_blink", 32'(blink_a),   32'h1);
    @(negedge clk);
    enable = 1'b1;
    do_tick(1'b0);
    chk("frz_release", 32'(slot_a), 32'h1);
    do_tick(1'b0);
    chk("frz_after", 32'(slot_a), 32'h1);

    // Blink pattern with HOLD_FRAMES=32, BLINK_WINDOW=16
    do_reset();
    blink_tbl = 32'h0F0F_FFFF;
    chk("bl_n0", 32'(blink_c), 32'h1);
    for (int k = 1; k < 32; k++) begin
      do_tick(1'b0);
      chk("bl_n", 32'(blink_c), 32'(blink_tbl[k]));
    end
    do_tick(1'b0);
    chk("bl_wrap",      32'(blink_c), 32'h1);
    chk("bl_wrap_slot", 32'(slot_c),  32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
